// File: rtl/mem_responder.sv
// Memory responder: single-port word array behind a request/ready
// handshake with a fixed number of wait states per access.
module mem_responder #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              Ready,
  output logic              Busy,
  output logic              Err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                op_wr_q, op_wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ready_q, busy_q, err_q, err_d;

  // Access strobe and its operands, valid on the edge entering S_DONE
  logic                acc_c;
  logic                acc_wr_c;
  logic [ADDR_W-1:0]   acc_addr_c;
  logic [DATA_W-1:0]   acc_wdata_c;
  logic                we_c;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  // Next-state, request capture and access decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_wr_d     = op_wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = 1'b0;
    acc_c       = 1'b0;
    acc_wr_c    = op_wr_q;
    acc_addr_c  = addr_q;
    acc_wdata_c = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (MemRead && MemWrite) begin
          // Illegal request: complete immediately, touch nothing
          state_d = S_DONE;
          err_d   = 1'b1;
        end else if (MemRead || MemWrite) begin
          op_wr_d = MemWrite;
          addr_d  = Addr;
          wdata_d = WriteData;
          cnt_d   = CNT_W'(WAIT_CYC);
          if (WAIT_CYC == 0) begin
            // No wait states: perform the access with the live operands
            state_d     = S_DONE;
            acc_c       = 1'b1;
            acc_wr_c    = MemWrite;
            acc_addr_c  = Addr;
            acc_wdata_c = WriteData;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          acc_c   = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (acc_c && !acc_wr_c) begin
      rdata_d = mem_q[acc_addr_c];
    end
    we_c = acc_c && acc_wr_c;
  end

  // State, captured request and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= (state_d == S_DONE);
      busy_q  <= (state_d != S_IDLE);
      err_q   <= err_d;
    end
  end

  // Array write; contents survive reset, but reset blocks a pending write
  always_ff @(posedge clk) begin
    if (!reset && we_c) begin
      mem_q[acc_addr_c] <= acc_wdata_c;
    end
  end

  assign ReadData = rdata_q;
  assign Ready    = ready_q;
  assign Busy     = busy_q;
  assign Err      = err_q;

endmodule
